// File: rtl/sr_ff_monitor.sv
// Checks an SR flip-flop under test against a cycle-accurate reference model.
// Build macro SR_MON_QB_CHECK_EN also checks that qb is the complement of q.
module sr_ff_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qb,
  input  logic             clr,
  output logic             exp_q,
  output logic             exp_vld,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             fail
);

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    TRACK   = 2'd1,
    INVALID = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   exp_q_nxt;
  logic   trk, q_err, qb_err, err, illegal;

  assign trk     = (state == TRACK);
  assign illegal = s & r;
  assign q_err   = trk & (q != exp_q);

`ifdef SR_MON_QB_CHECK_EN
  assign qb_err = trk & (qb == q);
`else
  logic unused_qb;
  assign unused_qb = qb;
  assign qb_err    = 1'b0;
`endif

  // Both checks failing on one edge still counts as a single error.
  assign err = q_err | qb_err;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= UNKNOWN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    exp_q_nxt = exp_q;
    case ({s, r})
      2'b10: begin state_nxt = TRACK; exp_q_nxt = 1'b1; end
      2'b01: begin state_nxt = TRACK; exp_q_nxt = 1'b0; end
      2'b11: state_nxt = INVALID;
      default: ;
    endcase
  end

  always_comb begin
    exp_vld = trk;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q       <= 1'b0;
      mismatch    <= 1'b0;
      err_cnt     <= '0;
      illegal_cnt <= '0;
      fail        <= 1'b0;
    end else begin
      exp_q    <= exp_q_nxt;
      mismatch <= err;
      // clr wins over same-edge increments but leaves the model alone.
      if (clr) begin
        err_cnt     <= '0;
        illegal_cnt <= '0;
        fail        <= 1'b0;
      end else begin
        if (err && (err_cnt != {CNT_W{1'b1}}))
          err_cnt <= err_cnt + 1'b1;
        if (illegal && (illegal_cnt != {CNT_W{1'b1}}))
          illegal_cnt <= illegal_cnt + 1'b1;
        if (err)
          fail <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sr_ff_monitor.md
SR_FF_MONITOR -- requirements
Module: sr_ff_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, the width of every event counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port s  input  1  set input presented to the flip-flop under test.
REQ-005 SHALL have port r  input  1  reset input presented to the flip-flop under test.
REQ-006 SHALL have port q  input  1  flip-flop output.
REQ-007 SHALL have port qb  input  1  flip-flop complementary output.
REQ-008 SHALL have port clr  input  1  synchronous clear of counters and fail; model state is untouched.
REQ-009 SHALL have port exp_q  output  1  model-predicted q.
REQ-010 SHALL have port exp_vld  output  1  high when exp_q is defined (state TRACK).
REQ-011 SHALL have port mismatch  output  1  one-cycle pulse on any detected error.
REQ-012 SHALL have port err_cnt  output  CNT_W  count of detected errors, saturating.
REQ-013 SHALL have port illegal_cnt  output  CNT_W  count of cycles sampled with s=r=1, saturating.
REQ-014 SHALL have port fail  output  1  sticky error flag.

Function
REQ-015 SHALL implement a three-state FSM: UNKNOWN, TRACK, INVALID; exp_vld=1 only in TRACK.
REQ-016 SHALL, at each rising edge k, sample s, r, q, qb together; the checks below use the state and exp_q held before edge k.
REQ-017 SHALL flag a q error at edge k when pre-edge state is TRACK and q != exp_q.
REQ-018 SHALL update the model at edge k: s,r=1,0 -> exp_q=1, TRACK; 0,1 -> exp_q=0, TRACK; 0,0 -> exp_q and state held; 1,1 -> INVALID, exp_q held.
REQ-019 SHALL, in UNKNOWN or INVALID, leave the state unchanged on s,r=0,0 and perform no q comparison.
REQ-020 SHALL increment illegal_cnt on every edge sampling s=r=1, including repeated cycles while in INVALID.
REQ-021 SHALL assert mismatch in the cycle after edge k if any error was detected at edge k (latency 1), and deassert it the following cycle unless another error is detected.
REQ-022 SHALL increment err_cnt by exactly 1 per edge with any error, even if both the q and qb checks fail.
REQ-023 SHALL saturate err_cnt and illegal_cnt at 2^CNT_W-1 with no wrap.
REQ-024 SHALL set fail on the first error and hold it until reset or clr.
REQ-025 SHALL give clr priority over same-edge increments: counters become 0 and fail becomes 0; mismatch still reflects the current edge's check; FSM and exp_q update normally.

Reset
REQ-026 SHALL, on rising edge with rst_n=0: state=UNKNOWN, exp_q=0, exp_vld=0, mismatch=0, err_cnt=0, illegal_cnt=0, fail=0.
REQ-027 SHALL perform no comparison, counting, or model update at an edge where rst_n=0; reset mid-run discards all prior tracking.

Configuration
REQ-028 SHALL, with macro SR_MON_QB_CHECK_EN defined, flag a qb error at any edge where pre-edge state is TRACK and qb != ~q.
REQ-029 SHALL, without SR_MON_QB_CHECK_EN, ignore qb entirely, so only q errors reach mismatch, err_cnt, and fail.

Verification
REQ-030 SHALL cover reset then s,r=0,0 for 3 edges with q=0 -> exp_vld=0, mismatch=0, err_cnt=0.
REQ-031 SHALL cover s,r=1,0 at edge 1, then 0,0 with a correct DUT (q=1, qb=0) for 4 edges -> exp_vld=1, exp_q=1, err_cnt=0.
REQ-032 SHALL cover TRACK with exp_q=1 and q forced to 0 for one edge -> mismatch high exactly one cycle, err_cnt=1, fail=1, fail still high 5 edges later.
REQ-033 SHALL cover s,r=1,1 for 2 edges, then 0,0 with arbitrary q -> illegal_cnt=2, state INVALID, no errors; then 0,1 -> TRACK, exp_q=0.
REQ-034 SHALL cover CNT_W=2 with 5 forced errors -> err_cnt=3; clr on the edge of a 6th error -> err_cnt=0, fail=0, mismatch pulse still present.
REQ-035 SHALL cover q=1 and qb=1 in TRACK with exp_q=1 -> with SR_MON_QB_CHECK_EN: err_cnt=1; without it: err_cnt=0.
